writeback: RTL and testbench

- Y86-64 write-back stage: the writer end of the register-file interface that the decode stage reads.
- Holds the M→W pipeline register and performs the register writes for dstE and dstM.
- Owns the architectural register file (r0–r14) and its two combinational read ports, which the decode stage uses.
- Tracks processor status, freezes on an exception or halt, and counts retired instructions.

---
 rtl/writeback.sv | 147 ++++++++++++++
 tb/tb_writeback.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/writeback.sv
// Y86-64 write-back stage: M->W pipeline register, architectural register file
// with two combinational read ports, status tracking and retired-instruction count.
module writeback #(
  parameter int unsigned NREGS = 15,
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic [2:0]       m_stat_i,
  input  logic [3:0]       m_icode_i,
  input  logic [3:0]       m_dstE_i,
  input  logic [3:0]       m_dstM_i,
  input  logic [63:0]      m_valE_i,
  input  logic [63:0]      m_valM_i,
  input  logic             W_stall_i,
  input  logic             W_bubble_i,
  input  logic [3:0]       srcA_i,
  input  logic [3:0]       srcB_i,
  output logic [63:0]      valA_o,
  output logic [63:0]      valB_o,
  output logic [3:0]       W_dstE_o,
  output logic [3:0]       W_dstM_o,
  output logic [63:0]      W_valE_o,
  output logic [63:0]      W_valM_o,
  output logic [2:0]       stat_o,
  output logic             halted_o,
  output logic [CNT_W-1:0] retire_cnt_o
);

  localparam logic [2:0] S_BUB = 3'd0;
  localparam logic [2:0] S_AOK = 3'd1;
  localparam logic [2:0] S_HLT = 3'd2;
  localparam logic [2:0] S_ADR = 3'd3;
  localparam logic [2:0] S_INS = 3'd4;
  localparam logic [3:0] RNONE = 4'hF;
  localparam logic [3:0] INOP  = 4'h1;

  typedef enum logic {RUN, HALTED} state_t;

  state_t      state, next_state;
  logic [2:0]  w_stat;
  logic [3:0]  w_icode;
  logic [3:0]  w_dstE;
  logic [3:0]  w_dstM;
  logic [63:0] w_valE;
  logic [63:0] w_valM;
  logic        fresh;
  logic        retire;
  logic        halt_now;
  logic [2:0]  stat_q;
  logic [2:0]  m_stat_n;
  logic [CNT_W-1:0] cnt;
  logic [63:0] regs [NREGS];
  logic        unused_icode;

  // Undefined status codes 5-7 behave as an invalid instruction.
  assign m_stat_n = (m_stat_i > S_INS) ? S_INS : m_stat_i;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      w_stat  <= S_BUB;
      w_icode <= INOP;
      w_dstE  <= RNONE;
      w_dstM  <= RNONE;
      w_valE  <= '0;
      w_valM  <= '0;
      fresh   <= 1'b0;
    end else if (W_bubble_i) begin
      w_stat  <= S_BUB;
      w_icode <= INOP;
      w_dstE  <= RNONE;
      w_dstM  <= RNONE;
      w_valE  <= '0;
      w_valM  <= '0;
      fresh   <= 1'b0;
    end else if (W_stall_i) begin
      fresh   <= 1'b0;
    end else begin
      w_stat  <= m_stat_n;
      w_icode <= m_icode_i;
      w_dstE  <= m_dstE_i;
      w_dstM  <= m_dstM_i;
      w_valE  <= m_valE_i;
      w_valM  <= m_valM_i;
      fresh   <= (m_stat_n != S_BUB);
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state <= RUN;
    else          state <= next_state;
  end

  always_comb begin
    next_state = state;
    retire     = 1'b0;
    halt_now   = 1'b0;
    case (state)
      RUN: begin
        if (w_stat == S_AOK) begin
          retire = 1'b1;
        end else if (w_stat == S_HLT || w_stat == S_ADR || w_stat == S_INS) begin
          halt_now   = 1'b1;
          next_state = HALTED;
        end
      end
      HALTED:  next_state = HALTED;
      default: next_state = RUN;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)      stat_q <= S_AOK;
    else if (halt_now) stat_q <= w_stat;
  end

  // fresh is cleared by a stall, so a held instruction is counted only once.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)              cnt <= '0;
    else if (retire && fresh)  cnt <= cnt + CNT_W'(1);
  end

  // dstM is written after dstE so it wins when both name the same register.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int unsigned i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (retire) begin
      if (w_dstE != RNONE) regs[w_dstE] <= w_valE;
      if (w_dstM != RNONE) regs[w_dstM] <= w_valM;
    end
  end

  assign valA_o = (srcA_i == RNONE) ? '0 : regs[srcA_i];
  assign valB_o = (srcB_i == RNONE) ? '0 : regs[srcB_i];

  assign W_dstE_o = (w_stat == S_AOK) ? w_dstE : RNONE;
  assign W_dstM_o = (w_stat == S_AOK) ? w_dstM : RNONE;
  assign W_valE_o = w_valE;
  assign W_valM_o = w_valM;

  assign stat_o       = stat_q;
  assign halted_o     = (state == HALTED);
  assign retire_cnt_o = cnt;

  assign unused_icode = ^w_icode;

endmodule

// File: tb/tb_writeback.sv
// Self-checking bench for writeback: transaction-level reference model compared
// every cycle, plus directed scenarios with hand-computed expectations.
module tb_writeback;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  m_stat;
  logic [3:0]  m_icode, m_dstE, m_dstM;
  logic [63:0] m_valE, m_valM;
  logic        W_stall, W_bubble;
  logic [3:0]  srcA, srcB;
  logic [63:0] valA, valB, W_valE, W_valM;
  logic [3:0]  W_dstE, W_dstM;
  logic [2:0]  stat;
  logic        halted;
  logic [31:0] retire_cnt;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  writeback #(.NREGS(15), .CNT_W(32)) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .m_stat_i(m_stat), .m_icode_i(m_icode), .m_dstE_i(m_dstE), .m_dstM_i(m_dstM),
    .m_valE_i(m_valE), .m_valM_i(m_valM),
    .W_stall_i(W_stall), .W_bubble_i(W_bubble),
    .srcA_i(srcA), .srcB_i(srcB), .valA_o(valA), .valB_o(valB),
    .W_dstE_o(W_dstE), .W_dstM_o(W_dstM), .W_valE_o(W_valE), .W_valM_o(W_valM),
    .stat_o(stat), .halted_o(halted), .retire_cnt_o(retire_cnt)
  );

  always #5 clk = ~clk;

  // Reference model: architectural state plus the instruction sitting in W.
  logic [63:0] mreg [15];
  logic [2:0]  mw_stat;
  logic [3:0]  mw_dstE, mw_dstM;
  logic [63:0] mw_valE, mw_valM;
  bit          mw_counted;
  bit          mhalted;
  logic [2:0]  mstat;
  logic [31:0] mcnt;

  task automatic mreset();
    for (int i = 0; i < 15; i++) mreg[i] = '0;
    mw_stat = 3'd0; mw_dstE = 4'hF; mw_dstM = 4'hF; mw_valE = '0; mw_valM = '0;
    mw_counted = 1'b1; mhalted = 1'b0; mstat = 3'd1; mcnt = '0;
  endtask

  function automatic logic [63:0] mread(input logic [3:0] r);
    return (r == 4'hF) ? 64'd0 : mreg[r];
  endfunction

  always @(negedge rst_n) mreset();

  always @(posedge clk) begin
    if (rst_n) begin
      if (!mhalted) begin
        if (mw_stat == 3'd1) begin
          if (mw_dstE != 4'hF) mreg[mw_dstE] = mw_valE;
          if (mw_dstM != 4'hF) mreg[mw_dstM] = mw_valM;
          if (!mw_counted) begin
            mcnt = mcnt + 1;
            mw_counted = 1'b1;
          end
        end else if (mw_stat != 3'd0) begin
          mhalted = 1'b1;
          mstat = mw_stat;
        end
      end
      if (W_bubble) begin
        mw_stat = 3'd0; mw_dstE = 4'hF; mw_dstM = 4'hF; mw_valE = '0; mw_valM = '0;
        mw_counted = 1'b1;
      end else if (!W_stall) begin
        mw_stat = (m_stat > 3'd4) ? 3'd4 : m_stat;
        mw_dstE = m_dstE; mw_dstM = m_dstM; mw_valE = m_valE; mw_valM = m_valM;
        mw_counted = 1'b0;
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en && rst_n) begin
      chk("valA", valA, mread(srcA));
      chk("valB", valB, mread(srcB));
      chk("W_dstE", 64'(W_dstE), 64'((mw_stat == 3'd1) ? mw_dstE : 4'hF));
      chk("W_dstM", 64'(W_dstM), 64'((mw_stat == 3'd1) ? mw_dstM : 4'hF));
      chk("W_valE", W_valE, mw_valE);
      chk("W_valM", W_valM, mw_valM);
      chk("stat", 64'(stat), 64'(mstat));
      chk("halted", 64'(halted), 64'(mhalted));
      chk("retire_cnt", 64'(retire_cnt), 64'(mcnt));
    end
  end

  task automatic drive(input logic [2:0] st, input logic [3:0] ic, input logic [3:0] de,
                       input logic [3:0] dm, input logic [63:0] ve, input logic [63:0] vm);
    m_stat = st; m_icode = ic; m_dstE = de; m_dstM = dm; m_valE = ve; m_valM = vm;
  endtask

  task automatic idle();
    drive(3'd0, 4'h1, 4'hF, 4'hF, 64'd0, 64'd0);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    mreset();
    rst_n = 1'b0; W_stall = 1'b0; W_bubble = 1'b0; srcA = 4'hF; srcB = 4'hF;
    idle();
    #12;
    srcA = 4'h3;
    #1;
    chk("rst stat", 64'(stat), 64'd1);
    chk("rst halted", 64'(halted), 64'd0);
    chk("rst cnt", 64'(retire_cnt), 64'd0);
    chk("rst W_dstE", 64'(W_dstE), 64'hF);
    chk("rst r3", valA, 64'd0);
    rst_n = 1'b1;
    chk_en = 1'b1;

    // irmovq -> r3
    drive(3'd1, 4'h3, 4'h3, 4'hF, 64'h1234, 64'd0);
    cyc(); idle();
    cyc(); srcA = 4'h3; srcB = 4'hF; #1;
    chk("irmovq r3", valA, 64'h1234);
    chk("irmovq valB F", valB, 64'd0);
    chk("irmovq cnt", 64'(retire_cnt), 64'd1);

    // popq with dstE==dstM: valM wins
    drive(3'd1, 4'hB, 4'h4, 4'h4, 64'h100, 64'h200);
    cyc(); idle();
    cyc(); srcA = 4'h4; #1;
    chk("popq r4", valA, 64'h200);
    chk("popq cnt", 64'(retire_cnt), 64'd2);

    // stalled opq counted once
    drive(3'd1, 4'h6, 4'h2, 4'hF, 64'd7, 64'd0);
    cyc(); W_stall = 1'b1; idle();
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("stall W_valE", W_valE, 64'd7);
    end
    W_stall = 1'b0;
    cyc(); srcA = 4'h2; #1;
    chk("stall r2", valA, 64'd7);
    chk("stall cnt", 64'(retire_cnt), 64'd3);

    // bubble beats stall
    drive(3'd1, 4'h3, 4'h5, 4'hF, 64'h55, 64'd0);
    W_stall = 1'b1; W_bubble = 1'b1;
    cyc(); #1;
    chk("bubble W_dstE", 64'(W_dstE), 64'hF);
    W_stall = 1'b0; W_bubble = 1'b0; idle();
    cyc(); srcA = 4'h5; #1;
    chk("bubble r5", valA, 64'd0);
    chk("bubble cnt", 64'(retire_cnt), 64'd3);

    // ADR fault, then later AOK writes ignored
    drive(3'd3, 4'h5, 4'h1, 4'hF, 64'hDEAD, 64'd0);
    cyc(); drive(3'd1, 4'h3, 4'h6, 4'hF, 64'h66, 64'd0);
    cyc(); srcA = 4'h1; #1;
    chk("adr stat", 64'(stat), 64'd3);
    chk("adr halted", 64'(halted), 64'd1);
    chk("adr r1", valA, 64'd0);
    idle();
    cyc(); cyc(); srcA = 4'h6; #1;
    chk("halted r6", valA, 64'd0);
    chk("halted cnt", 64'(retire_cnt), 64'd3);

    // asynchronous reset between edges while halted
    #2;
    rst_n = 1'b0; srcA = 4'h3; srcB = 4'h4;
    #1;
    chk("async stat", 64'(stat), 64'd1);
    chk("async halted", 64'(halted), 64'd0);
    chk("async r3", valA, 64'd0);
    chk("async r4", valB, 64'd0);
    chk("async cnt", 64'(retire_cnt), 64'd0);
    cyc();
    #2 rst_n = 1'b1;

    // stat 7 behaves as INS
    drive(3'd7, 4'hF, 4'h1, 4'hF, 64'h77, 64'd0);
    cyc(); idle();
    cyc(); srcA = 4'h1; #1;
    chk("ins stat", 64'(stat), 64'd4);
    chk("ins halted", 64'(halted), 64'd1);
    chk("ins r1", valA, 64'd0);
    cyc();

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
